// File: rtl/mem_responder.sv
// Single-port byte-addressable memory behind a valid/ready request/response handshake
// with a fixed, parameterised response latency and misalignment/illegal-size errors.
module mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWE,
    input  logic [31:0] ReqAddr,
    input  logic [1:0]  ReqSize,
    input  logic [31:0] ReqData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespData,
    output logic        RespErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   data_q, data_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          mem_we;
    logic          cur_we;
    logic [AW+1:0] cur_addr;
    logic [1:0]    cur_size;
    logic [31:0]   cur_data;
    logic [AW-1:0] cur_idx;
    logic          cur_err;
    logic [3:0]    cur_be;
    logic [31:0]   cur_wdata;
    logic [31:0]   cur_word;
    logic [31:0]   cur_load;

    // With LATENCY=1 the response is formed on the acceptance edge itself, so the
    // operands come straight from the request port; otherwise from the captured copy.
    always_comb begin
        accept = ReqValid && ready_q && (state_q == IDLE);
        if (state_q == IDLE) begin
            cur_we   = ReqWE;
            cur_addr = ReqAddr[AW+1:0];
            cur_size = ReqSize;
            cur_data = ReqData;
        end else begin
            cur_we   = we_q;
            cur_addr = addr_q;
            cur_size = size_q;
            cur_data = data_q;
        end
        cur_idx = cur_addr[AW+1:2];
        cur_err = (cur_size == 2'b11) ||
                  ((cur_size == 2'b01) && cur_addr[0]) ||
                  ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
        cur_word = mem[cur_idx];
        case (cur_size)
            2'b00: begin
                cur_be    = 4'b0001 << cur_addr[1:0];
                cur_wdata = {4{cur_data[7:0]}};
                cur_load  = (cur_word >> {cur_addr[1:0], 3'b000}) & 32'h0000_00FF;
            end
            2'b01: begin
                cur_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                cur_wdata = {2{cur_data[15:0]}};
                cur_load  = (cur_word >> {cur_addr[1], 4'b0000}) & 32'h0000_FFFF;
            end
            default: begin
                cur_be    = 4'b1111;
                cur_wdata = cur_data;
                cur_load  = cur_word;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        data_d     = data_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = ReqWE;
                    addr_d  = ReqAddr[AW+1:0];
                    size_d  = ReqSize;
                    data_d  = ReqData;
                    ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            RESP: begin
                if (RespReady) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
        // Store commit and load sampling share the edge that enters RESP; reset wins.
        if (enter_resp) begin
            state_d = RESP;
            cnt_d   = 4'd0;
            valid_d = 1'b1;
            err_d   = cur_err;
            rdata_d = (cur_err || cur_we) ? 32'h0 : cur_load;
            mem_we  = cur_we && !cur_err && !RST;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            data_q  <= 32'h0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ReqReady  = ready_q;
    assign RespValid = valid_q;
    assign RespData  = rdata_q;
    assign RespErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (LATENCY=2 and LATENCY=3) share the
// request bus; each directed step checks latency, data, error and the handshake.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_data = 32'h0;

    logic        req_valid2 = 1'b0, resp_ready2 = 1'b0;
    logic        req_ready2, resp_valid2, resp_err2;
    logic [31:0] resp_data2;

    logic        req_valid3 = 1'b0, resp_ready3 = 1'b0;
    logic        req_ready3, resp_valid3, resp_err3;
    logic [31:0] resp_data3;

    logic        sel = 1'b0;
    logic        cur_ready, cur_valid, cur_err;
    logic [31:0] cur_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) u_dut2 (
        .CLK(clk), .RST(rst), .ReqValid(req_valid2), .ReqReady(req_ready2),
        .ReqWE(req_we), .ReqAddr(req_addr), .ReqSize(req_size), .ReqData(req_data),
        .RespValid(resp_valid2), .RespReady(resp_ready2), .RespData(resp_data2),
        .RespErr(resp_err2)
    );

    mem_responder #(.LATENCY(3), .DEPTH_WORDS(1024)) u_dut3 (
        .CLK(clk), .RST(rst), .ReqValid(req_valid3), .ReqReady(req_ready3),
        .ReqWE(req_we), .ReqAddr(req_addr), .ReqSize(req_size), .ReqData(req_data),
        .RespValid(resp_valid3), .RespReady(resp_ready3), .RespData(resp_data3),
        .RespErr(resp_err3)
    );

    assign cur_ready = sel ? req_ready3  : req_ready2;
    assign cur_valid = sel ? resp_valid3 : resp_valid2;
    assign cur_err   = sel ? resp_err3   : resp_err2;
    assign cur_data  = sel ? resp_data3  : resp_data2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full request: bounded wait for ReqReady, accept, scramble the request bus,
    // measure latency in edges counting the acceptance edge, optionally stall RespReady.
    task automatic do_req(input logic which, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] data,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int hold, input string tag);
        int n;
        logic [31:0] held;
        sel = which;
        @(negedge clk);
        n = 0;
        while (!cur_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/ready"}, 32'(cur_ready), 32'd1);
        req_we   = we;
        req_addr = addr;
        req_size = size;
        req_data = data;
        if (which) begin
            req_valid3  = 1'b1;
            resp_ready3 = (hold == 0);
        end else begin
            req_valid2  = 1'b1;
            resp_ready2 = (hold == 0);
        end
        @(posedge clk);
        #1;
        req_valid2 = 1'b0;
        req_valid3 = 1'b0;
        req_we     = ~we;
        req_addr   = 32'hFFFF_FFFC;
        req_size   = 2'b11;
        req_data   = 32'h0BAD_0BAD;
        n = 1;
        while (!cur_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/lat"}, 32'(n), 32'(exp_lat));
        check({tag, "/data"}, cur_data, exp_data);
        check({tag, "/err"}, 32'(cur_err), 32'(exp_err));
        if (hold > 0) begin
            held = cur_data;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({tag, "/hold_valid"}, 32'(cur_valid), 32'd1);
                check({tag, "/hold_data"}, cur_data, held);
                check({tag, "/hold_ready"}, 32'(cur_ready), 32'd0);
            end
            if (which) resp_ready3 = 1'b1;
            else       resp_ready2 = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "/done_valid"}, 32'(cur_valid), 32'd0);
        check({tag, "/done_ready"}, 32'(cur_ready), 32'd1);
    endtask

    initial begin
        logic seen;

        @(posedge clk);
        #1;
        check("rst/valid", 32'(resp_valid2), 32'd0);
        check("rst/err", 32'(resp_err2), 32'd0);
        check("rst/data", resp_data2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst/ready2", 32'(req_ready2), 32'd1);
        check("rst/ready3", 32'(req_ready3), 32'd1);

        do_req(0, 1, 32'h10, 2'b10, 32'hDEAD_BEEF, 32'h0,         0, 2, 0, "st_w_10");
        do_req(0, 0, 32'h10, 2'b10, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, "ld_w_10");
        do_req(0, 1, 32'h13, 2'b00, 32'hFFFF_FF5A, 32'h0,         0, 2, 0, "st_b_13");
        do_req(0, 0, 32'h10, 2'b10, 32'h0,         32'h5AAD_BEEF, 0, 2, 0, "ld_w_10b");
        do_req(0, 0, 32'h13, 2'b00, 32'h0,         32'h0000_005A, 0, 2, 0, "ld_b_13");
        do_req(0, 0, 32'h12, 2'b01, 32'h0,         32'h0000_5AAD, 0, 2, 0, "ld_h_12");
        do_req(0, 0, 32'h11, 2'b00, 32'h0,         32'h0000_00BE, 0, 2, 0, "ld_b_11");
        do_req(0, 0, 32'h10, 2'b01, 32'h0,         32'h0000_BEEF, 0, 2, 0, "ld_h_10");
        do_req(0, 0, 32'h11, 2'b01, 32'h0,         32'h0,         1, 2, 0, "err_h_11");
        do_req(0, 0, 32'h12, 2'b10, 32'h0,         32'h0,         1, 2, 0, "err_w_12");
        do_req(0, 0, 32'h10, 2'b11, 32'h0,         32'h0,         1, 2, 0, "err_sz3");
        do_req(0, 1, 32'h12, 2'b10, 32'hFFFF_FFFF, 32'h0,         1, 2, 0, "err_st_w_12");
        do_req(0, 1, 32'h11, 2'b01, 32'hFFFF_FFFF, 32'h0,         1, 2, 0, "err_st_h_11");
        do_req(0, 0, 32'h10, 2'b10, 32'h0,         32'h5AAD_BEEF, 0, 2, 0, "ld_w_10c");

        do_req(0, 1, 32'h14, 2'b10, 32'h0,         32'h0,         0, 2, 0, "st_w_14");
        do_req(0, 1, 32'h16, 2'b01, 32'hA5A5_1234, 32'h0,         0, 2, 0, "st_h_16");
        do_req(0, 0, 32'h14, 2'b10, 32'h0,         32'h1234_0000, 0, 2, 0, "ld_w_14");

        do_req(0, 0, 32'h10, 2'b10, 32'h0,         32'h5AAD_BEEF, 0, 2, 5, "hold");

        do_req(0, 1, 32'h1000, 2'b10, 32'hCAFE_F00D, 32'h0,        0, 2, 0, "st_wrap");
        do_req(0, 0, 32'h0,    2'b10, 32'h0,        32'hCAFE_F00D, 0, 2, 0, "ld_wrap");

        do_req(1, 1, 32'h20, 2'b10, 32'h0,         32'h0,         0, 3, 0, "l3_st_20");
        do_req(1, 0, 32'h20, 2'b10, 32'h0,         32'h0,         0, 3, 0, "l3_ld_20");

        // Reset lands on the edge that would otherwise commit the store.
        sel = 1'b1;
        @(negedge clk);
        req_we      = 1'b1;
        req_addr    = 32'h20;
        req_size    = 2'b10;
        req_data    = 32'h1234_5678;
        req_valid3  = 1'b1;
        resp_ready3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        check("rstwait/valid_e0", 32'(resp_valid3), 32'd0);
        @(posedge clk);
        #1;
        check("rstwait/valid_e1", 32'(resp_valid3), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen = seen | resp_valid3;
        end
        check("rstwait/never_valid", 32'(seen), 32'd0);
        check("rstwait/ready", 32'(req_ready3), 32'd1);
        do_req(1, 0, 32'h20, 2'b10, 32'h0,         32'h0,         0, 3, 0, "l3_ld_after_rst");
        do_req(0, 0, 32'h10, 2'b10, 32'h0,         32'h5AAD_BEEF, 0, 2, 0, "l2_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request acceptance edge to first RespValid cycle; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 1024: storage size in 32-bit words; power of two.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 ReqValid  input  1  initiator presents a request.
REQ-006 ReqReady  output  1  responder can accept a request this cycle.
REQ-007 ReqWE  input  1  1 = store, 0 = load.
REQ-008 ReqAddr  input  32  byte address.
REQ-009 ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 ReqData  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-011 RespValid  output  1  response present.
REQ-012 RespReady  input  1  initiator consumes response.
REQ-013 RespData  output  32  load data, zero-extended and right-aligned; 0 for stores and errors.
REQ-014 RespErr  output  1  request rejected (misaligned or illegal size).

Function
REQ-015 FSM states IDLE, WAIT, RESP; ReqReady = 1 only in IDLE.
REQ-016 Acceptance: edge where ReqValid && ReqReady; ReqWE/ReqAddr/ReqSize/ReqData captured into internal registers; request inputs ignored at all other times.
REQ-017 IDLE -> WAIT on acceptance when LATENCY > 1; IDLE -> RESP directly when LATENCY = 1.
REQ-018 WAIT: 4-bit down-counter loaded with LATENCY-1 at acceptance; decrements each cycle; WAIT -> RESP on the edge where counter reaches 1.
REQ-019 Result: RespValid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 RESP: RespValid, RespData, RespErr held stable until RespReady = 1; RESP -> IDLE on edge where RespValid && RespReady; ReqReady = 1 the following cycle (no back-to-back acceptance in the handshake cycle).
REQ-021 Memory little-endian, byte addressable; word index = captured address[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (aliasing/wrap, no error).
REQ-022 Byte load: RespData = {24'b0, selected byte by addr[1:0]}; halfword: {16'b0, halfword by addr[1]}; word: full word.
REQ-023 Store writes only the addressed byte lanes (byte enables derived from size and addr[1:0]); other lanes unchanged.
REQ-024 Store commits on the edge entering RESP; a load accepted afterwards returns the new data.
REQ-025 Load data sampled on the edge entering RESP.
REQ-026 Error: size 11, halfword with addr[0] = 1, or word with addr[1:0] != 00 -> RespErr = 1, RespData = 0, no memory write; timing per REQ-019 unchanged.
REQ-027 Stores return RespErr = 0 (unless REQ-026) and RespData = 0.
REQ-028 ReqValid dropping during WAIT/RESP has no effect on the in-flight request.

Reset
REQ-029 RST = 1 at an edge: state -> IDLE, counter -> 0, RespValid = 0, RespErr = 0, RespData = 0; ReqReady = 1 the cycle after RST deasserts.
REQ-030 RST mid-operation (WAIT or RESP) abandons the request; a store not yet committed (still in WAIT) is never written.
REQ-031 Storage array is not cleared by RST; contents undefined until written.
REQ-032 RST has priority over acceptance and handshake in the same cycle.

Verification
REQ-033 LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> RespValid 2 cycles after each acceptance, load RespData = 0xDEADBEEF, RespErr = 0.
REQ-034 Store byte 0x5A @0x13 over 0xDEADBEEF, load word @0x10 -> 0x5AADBEEF; load byte @0x13 -> 0x0000005A; load halfword @0x12 -> 0x00005AAD.
REQ-035 Load halfword @0x11, load word @0x12, and ReqSize = 11 -> RespErr = 1, RespData = 0; subsequent load word @0x10 unchanged (0x5AADBEEF).
REQ-036 Hold RespReady = 0 for 5 cycles in RESP -> RespValid/RespData stable, ReqReady = 0 throughout; ReqReady = 1 one cycle after RespReady handshake.
REQ-037 Store word 0x12345678 @0x20, assert RST during WAIT (LATENCY = 3) -> RespValid never asserted, ReqReady = 1 after reset; later load @0x20 does not return 0x12345678 if previously written with 0x0.
REQ-038 DEPTH_WORDS = 1024: store word 0xCAFEF00D @0x1000, load word @0x0 -> 0xCAFEF00D (address wrap).
